// File: rtl/dram_device_model_pkg.sv
// Shared types, default timing and command decode for the single-bank DRAM model.
package dram_pkg;

  typedef enum logic [2:0] {
    NOP,
    ACT,
    PRE,
    RD,
    WR,
    ILL
  } dram_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_CAS_IDLE   = 3'd1,
    ERR_TRCD       = 3'd2,
    ERR_ACT_ACTIVE = 3'd3,
    ERR_TRP        = 3'd4,
    ERR_ILL        = 3'd5
  } dram_err_e;

  typedef enum logic {
    IDLE,
    ACTIVE
  } bank_state_e;

  localparam int T_RCD_DEF   = 5;
  localparam int T_RP_DEF    = 5;
  localparam int CAS_LAT_DEF = 5;

  // Deselected or RAS/CAS both high is a NOP; RAS and CAS together is never legal.
  function automatic dram_cmd_e decode_cmd(input logic csn, input logic rasn,
                                           input logic casn, input logic [3:0] wen);
    dram_cmd_e cmd;
    cmd = ILL;
    if (csn) begin
      cmd = NOP;
    end else if (rasn && casn) begin
      cmd = NOP;
    end else if (!rasn && casn) begin
      if (wen == 4'hF) begin
        cmd = ACT;
      end else if (wen == 4'h0) begin
        cmd = PRE;
      end
    end else if (rasn && !casn) begin
      cmd = (wen == 4'hF) ? RD : WR;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/dram_device_model_read_pipe.sv
// CAS-latency read pipeline: a CAS_LAT-deep {valid,data} shift register feeding
// a registered VALID strobe and a Q register that holds its last value.
module dram_read_pipe #(
  parameter int CAS_LAT = 5
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        i_push,
  input  logic [31:0] i_data,
  output logic        o_valid,
  output logic [31:0] o_data
);

  logic [CAS_LAT-1:0] r_valid;
  logic [31:0]        r_data [CAS_LAT];
  logic               r_outValid;
  logic [31:0]        r_outData;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_valid    <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      r_valid[0] <= i_push;
      for (int i = 1; i < CAS_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
      r_outValid <= r_valid[CAS_LAT-1];
      if (r_valid[CAS_LAT-1]) begin
        r_outData <= r_data[CAS_LAT-1];
      end
    end
  end

  // Payload only matters where its valid bit is set, so it needs no reset.
  always_ff @(posedge ACLK) begin
    r_data[0] <= i_data;
    for (int i = 1; i < CAS_LAT; i++) begin
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid = r_outValid;
  assign o_data  = r_outData;

endmodule

// File: rtl/dram_device_model.sv
// Single-bank DRAM pin-level responder: row buffer, byte-strobed writes, CAS-latency reads.
// Define DRAM_TIMING_CHECK_EN to enable tRCD/tRP/protocol checking with sticky error capture.
module dram_device_model
  import dram_pkg::*;
#(
  parameter int ROW_BITS     = 11,
  parameter int COL_BITS     = 10,
  parameter int MEM_IDX_BITS = 16,
  parameter int T_RCD        = T_RCD_DEF,
  parameter int T_RP         = T_RP_DEF,
  parameter int CAS_LAT      = CAS_LAT_DEF
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic [3:0]  WEn,
  input  logic [10:0] A,
  input  logic [31:0] D,
  output logic [31:0] Q,
  output logic        VALID,
  output logic        row_open_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
);

  bank_state_e              r_state;
  logic                     r_rowOpen;
  logic [ROW_BITS-1:0]      r_openRow;
  logic [31:0]              r_mem [2**MEM_IDX_BITS];

  dram_cmd_e                w_cmd;
  logic [MEM_IDX_BITS-1:0]  w_idx;
  logic [31:0]              w_rdData;
  logic                     w_doAct;
  logic                     w_doPre;
  logic                     w_doRd;
  logic                     w_doWr;

  assign w_cmd    = decode_cmd(CSn, RASn, CASn, WEn);
  assign w_idx    = MEM_IDX_BITS'({r_openRow, A[COL_BITS-1:0]});
  assign w_rdData = r_mem[w_idx];

`ifdef DRAM_TIMING_CHECK_EN
  localparam logic [2:0] RCD_MIN = 3'(T_RCD - 1);
  localparam logic [2:0] RP_MIN  = 3'(T_RP - 1);

  logic [2:0] r_rcdCnt;
  logic [2:0] r_rpCnt;
  logic       r_err;
  dram_err_e  r_errCode;
  dram_err_e  w_err;

  always_comb begin
    w_err = ERR_NONE;
    case (w_cmd)
      ACT: begin
        if (r_state == ACTIVE) begin
          w_err = ERR_ACT_ACTIVE;
        end else if (r_rpCnt < RP_MIN) begin
          w_err = ERR_TRP;
        end
      end
      RD, WR: begin
        if (r_state == IDLE) begin
          w_err = ERR_CAS_IDLE;
        end else if (r_rcdCnt < RCD_MIN) begin
          w_err = ERR_TRCD;
        end
      end
      ILL:     w_err = ERR_ILL;
      default: w_err = ERR_NONE;
    endcase
  end

  // Erroring commands are dropped; PRE in IDLE is a harmless no-op.
  assign w_doAct = (w_cmd == ACT) && (w_err == ERR_NONE);
  assign w_doPre = (w_cmd == PRE) && (r_state == ACTIVE);
  assign w_doRd  = (w_cmd == RD)  && (w_err == ERR_NONE);
  assign w_doWr  = (w_cmd == WR)  && (w_err == ERR_NONE);

  // Timers start saturated so the very first ACT after reset is legal.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rcdCnt <= 3'd7;
      r_rpCnt  <= 3'd7;
    end else begin
      if (w_doAct) begin
        r_rcdCnt <= 3'd0;
      end else if (r_rcdCnt != 3'd7) begin
        r_rcdCnt <= r_rcdCnt + 3'd1;
      end
      if (w_doPre) begin
        r_rpCnt <= 3'd0;
      end else if (r_rpCnt != 3'd7) begin
        r_rpCnt <= r_rpCnt + 3'd1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_err     <= 1'b0;
      r_errCode <= ERR_NONE;
    end else if (!r_err && (w_err != ERR_NONE)) begin
      r_err     <= 1'b1;
      r_errCode <= w_err;
    end
  end

  assign err_o      = r_err;
  assign err_code_o = r_errCode;
`else
  assign w_doAct = (w_cmd == ACT);
  assign w_doPre = (w_cmd == PRE) && (r_state == ACTIVE);
  assign w_doRd  = (w_cmd == RD);
  assign w_doWr  = (w_cmd == WR);

  assign err_o      = 1'b0;
  assign err_code_o = 3'd0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= IDLE;
      r_rowOpen <= 1'b0;
      r_openRow <= '0;
    end else if (w_doAct) begin
      r_state   <= ACTIVE;
      r_rowOpen <= 1'b1;
      r_openRow <= A[ROW_BITS-1:0];
    end else if (w_doPre) begin
      r_state   <= IDLE;
      r_rowOpen <= 1'b0;
    end
  end

  // The array survives reset so data written before a reset can be read back.
  always_ff @(posedge ACLK) begin
    if (w_doWr) begin
      for (int i = 0; i < 4; i++) begin
        if (!WEn[i]) begin
          r_mem[w_idx][8*i +: 8] <= D[8*i +: 8];
        end
      end
    end
  end

  dram_read_pipe #(
    .CAS_LAT (CAS_LAT)
  ) u_readPipe (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .i_push  (w_doRd),
    .i_data  (w_rdData),
    .o_valid (VALID),
    .o_data  (Q)
  );

  assign row_open_o = r_rowOpen;

endmodule

// File: tb/tb_dram_device_model.sv
// Scoreboard bench for dram_device_model: reads queue their expected data and arrival cycle,
// and a negedge monitor checks every VALID pulse against that queue.
module tb_dram_device_model;

  localparam int CAS_LAT = 5;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        CSn = 1'b1;
  logic        RASn = 1'b1;
  logic        CASn = 1'b1;
  logic [3:0]  WEn = 4'hF;
  logic [10:0] A = '0;
  logic [31:0] D = '0;
  logic [31:0] Q;
  logic        VALID;
  logic        rowOpen;
  logic        err;
  logic [2:0]  errCode;

  int testCount = 0;
  int failCount = 0;
  int cycle = 0;
  int lastEdge = 0;

  typedef struct {
    int          edgeNo;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];

  dram_device_model dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .CSn        (CSn),
    .RASn       (RASn),
    .CASn       (CASn),
    .WEn        (WEn),
    .A          (A),
    .D          (D),
    .Q          (Q),
    .VALID      (VALID),
    .row_open_o (rowOpen),
    .err_o      (err),
    .err_code_o (errCode)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Every VALID pulse must match the oldest outstanding read, in data and in arrival cycle.
  always @(negedge ACLK) begin : monitor
    exp_t e;
    if (VALID !== 1'b0) begin
      if (expQ.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL unexpectedValid: got VALID=%b at cycle %0d, expected no read data", VALID, cycle);
      end else begin
        e = expQ.pop_front();
        checkOutput("validCycle", cycle, e.edgeNo);
        checkOutput("readData", Q, e.data);
      end
    end
  end

  // Drive one command so it is sampled on the next rising edge, then return the pins to NOP.
  task automatic applyStimulus(input logic ras, input logic cas, input logic [3:0] wen,
                               input logic [10:0] addr, input logic [31:0] data);
    @(negedge ACLK);
    CSn  = 1'b0;
    RASn = ras;
    CASn = cas;
    WEn  = wen;
    A    = addr;
    D    = data;
    @(posedge ACLK);
    #1;
    lastEdge = cycle;
    CSn  = 1'b1;
    RASn = 1'b1;
    CASn = 1'b1;
    WEn  = 4'hF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
  endtask

  task automatic doAct(input logic [10:0] row);
    applyStimulus(1'b0, 1'b1, 4'hF, row, 32'h0);
  endtask

  task automatic doPre();
    applyStimulus(1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
  endtask

  task automatic doWr(input logic [10:0] col, input logic [3:0] wen, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, wen, col, data);
  endtask

  task automatic doRd(input logic [10:0] col, input logic [31:0] data, input bit expectData);
    exp_t e;
    applyStimulus(1'b1, 1'b0, 4'hF, col, 32'h0);
    if (expectData) begin
      e.edgeNo = lastEdge + CAS_LAT;
      e.data   = data;
      expQ.push_back(e);
    end
  endtask

  task automatic pulseReset();
    @(negedge ACLK);
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    // Reset values
    repeat (3) @(negedge ACLK);
    #1;
    checkOutput("resetQ", Q, 32'h0);
    checkOutput("resetValid", {31'd0, VALID}, 32'd0);
    checkOutput("resetRowOpen", {31'd0, rowOpen}, 32'd0);
    checkOutput("resetErr", {31'd0, err}, 32'd0);
    checkOutput("resetErrCode", {29'd0, errCode}, 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Full-word write then read after tRCD
    doAct(11'h001);
    checkOutput("actRowOpen", {31'd0, rowOpen}, 32'd1);
    idle(4);
    doWr(11'h004, 4'h0, 32'hDEADBEEF);
    idle(5);
    doRd(11'h004, 32'hDEADBEEF, 1'b1);
    idle(CAS_LAT + 2);
    checkOutput("basicErr", {31'd0, err}, 32'd0);

    // Byte-strobed overwrite keeps the upper two bytes
    doWr(11'h008, 4'h0, 32'h11223344);
    doWr(11'h008, 4'b1100, 32'hAABBCCDD);
    doRd(11'h008, 32'h1122CCDD, 1'b1);
    idle(CAS_LAT + 2);

    // Back-to-back reads, then Q must hold the last word
    doWr(11'h010, 4'h0, 32'hA0A0A0A0);
    doWr(11'h011, 4'h0, 32'hB1B1B1B1);
    doWr(11'h012, 4'h0, 32'hC2C2C2C2);
    doRd(11'h010, 32'hA0A0A0A0, 1'b1);
    doRd(11'h011, 32'hB1B1B1B1, 1'b1);
    doRd(11'h012, 32'hC2C2C2C2, 1'b1);
    idle(CAS_LAT + 4);
    #1;
    checkOutput("holdValid", {31'd0, VALID}, 32'd0);
    checkOutput("holdQ", Q, 32'hC2C2C2C2);
    checkOutput("pendingAfterBurst", expQ.size(), 32'd0);

    // Reset while a read is in flight: the read is lost, the array is not
    doRd(11'h004, 32'hDEADBEEF, 1'b0);
    idle(1);
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    checkOutput("midResetValid", {31'd0, VALID}, 32'd0);
    checkOutput("midResetQ", Q, 32'h0);
    checkOutput("midResetRowOpen", {31'd0, rowOpen}, 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    idle(CAS_LAT + 4);
    #1;
    checkOutput("postResetQ", Q, 32'h0);
    checkOutput("pendingAfterReset", expQ.size(), 32'd0);
    doAct(11'h001);
    idle(4);
    doRd(11'h004, 32'hDEADBEEF, 1'b1);
    idle(CAS_LAT + 2);

    // CAS three cycles after ACT
    doPre();
    idle(4);
    doAct(11'h001);
    idle(2);
`ifdef DRAM_TIMING_CHECK_EN
    doRd(11'h004, 32'hDEADBEEF, 1'b0);
    idle(CAS_LAT + 3);
    checkOutput("trcdErr", {31'd0, err}, 32'd1);
    checkOutput("trcdErrCode", {29'd0, errCode}, 32'd2);
`else
    doRd(11'h004, 32'hDEADBEEF, 1'b1);
    idle(CAS_LAT + 3);
    checkOutput("trcdErr", {31'd0, err}, 32'd0);
`endif
    pulseReset();

    // ACT two cycles after PRE
    doAct(11'h001);
    idle(4);
    doPre();
    idle(1);
    doAct(11'h001);
`ifdef DRAM_TIMING_CHECK_EN
    checkOutput("trpRowOpen", {31'd0, rowOpen}, 32'd0);
    checkOutput("trpErr", {31'd0, err}, 32'd1);
    checkOutput("trpErrCode", {29'd0, errCode}, 32'd4);
`else
    checkOutput("trpRowOpen", {31'd0, rowOpen}, 32'd1);
    checkOutput("trpErr", {31'd0, err}, 32'd0);
`endif
    pulseReset();

    // Fresh run: ACT five cycles after PRE is legal, and earlier writes are still there
    doAct(11'h001);
    doPre();
    checkOutput("preRowClosed", {31'd0, rowOpen}, 32'd0);
    idle(4);
    doAct(11'h001);
    checkOutput("legalActRowOpen", {31'd0, rowOpen}, 32'd1);
    checkOutput("legalActErr", {31'd0, err}, 32'd0);
    checkOutput("legalActErrCode", {29'd0, errCode}, 32'd0);
    idle(4);
    doRd(11'h008, 32'h1122CCDD, 1'b1);
    idle(CAS_LAT + 4);
    #1;
    checkOutput("pendingAtEnd", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
